argmax_classifier: RTL and testbench

- Consumes the accumulator outputs of a dense layer once that layer signals completion.
- Scans the neurons serially, one per cycle, and reports the index of the largest signed value as the predicted class.
- Sits after the final dense layer of the network and presents the class through a valid/ack handshake to the downstream consumer (display, UART, test harness).

---
 rtl/argmax_classifier.sv | 138 +++++++++++++
 tb/tb_argmax_classifier.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// argmax_classifier
// Picks the index of the largest signed neuron accumulator once the final
// dense layer reports completion. The inputs are captured on the start edge.
// One neuron is then compared per cycle. The winner is held on a
// valid/ack handshake until the consumer takes it.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-high reset
//   layer_terminat completion level from the dense layer (rising edge starts a scan)
//   date_intrare   numar_neuroni signed accumulators, 4*latime bits each
//   clasa          winning neuron index (held until the next result)
//   clasa_valid    clasa is valid; held until clasa_ack
//   clasa_ack      consumer accepts clasa
//   busy           high while scanning or holding a result
//   clasa_valoare  winning value (only with ARGMAX_MAX_VALUE_OUT_EN defined)
//
// Optional feature macro: ARGMAX_MAX_VALUE_OUT_EN
module argmax_classifier #(
  parameter int numar_neuroni = 10,
  parameter int latime        = 8,
  localparam int IDX_W        = (numar_neuroni > 1) ? $clog2(numar_neuroni) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      layer_terminat,
  input  logic signed [4*latime-1:0] date_intrare [0:numar_neuroni-1],
  output logic [IDX_W-1:0]          clasa,
  output logic                      clasa_valid,
  input  logic                      clasa_ack,
  output logic                      busy
`ifdef ARGMAX_MAX_VALUE_OUT_EN
  ,
  output logic signed [4*latime-1:0] clasa_valoare
`endif
);

  localparam int DW = 4*latime;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(numar_neuroni-1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state;
  logic                  lt_q;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      best_idx;
  logic signed [DW-1:0]  best_val;
  logic signed [DW-1:0]  snap [0:numar_neuroni-1];

  logic                  start;
  logic signed [DW-1:0]  cur_val;
  logic                  take;
  logic [IDX_W-1:0]      nxt_idx;
  logic signed [DW-1:0]  nxt_val;

  // A start is a 0->1 transition. lt_q resets to 0, so a level that is
  // already high when reset releases also counts as a start.
  assign start = layer_terminat & ~lt_q;

  // With a single neuron the scan step never runs. Use a constant index so
  // that a one-entry snapshot is never indexed out of range.
  if (numar_neuroni > 1) begin : g_cur
    assign cur_val = snap[idx];
  end else begin : g_cur1
    assign cur_val = snap[0];
  end

  // The compare is strict, so on a tie the earlier (lower) index is kept.
  assign take    = cur_val > best_val;
  assign nxt_idx = take ? idx : best_idx;
  assign nxt_val = take ? cur_val : best_val;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lt_q        <= 1'b0;
      idx         <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      clasa       <= '0;
      clasa_valid <= 1'b0;
      busy        <= 1'b0;
`ifdef ARGMAX_MAX_VALUE_OUT_EN
      clasa_valoare <= '0;
`endif
      for (int i = 0; i < numar_neuroni; i++) snap[i] <= '0;
    end else begin
      // Always track the level, so starts seen outside IDLE are consumed and lost.
      lt_q <= layer_terminat;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < numar_neuroni; i++) snap[i] <= date_intrare[i];
            best_val <= date_intrare[0];
            best_idx <= '0;
            idx      <= IDX_W'(1);
            busy     <= 1'b1;
            if (numar_neuroni == 1) begin
              state       <= DONE;
              clasa       <= '0;
              clasa_valid <= 1'b1;
`ifdef ARGMAX_MAX_VALUE_OUT_EN
              clasa_valoare <= date_intrare[0];
`endif
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          best_val <= nxt_val;
          best_idx <= nxt_idx;
          if (idx == LAST) begin
            // Publish the result of this final compare directly, so it does
            // not cost an extra cycle.
            state       <= DONE;
            clasa       <= nxt_idx;
            clasa_valid <= 1'b1;
`ifdef ARGMAX_MAX_VALUE_OUT_EN
            clasa_valoare <= nxt_val;
`endif
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (clasa_ack) begin
            clasa_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
module tb_argmax_classifier;
  localparam int N = 10;
  localparam int L = 8;
  localparam int W = 4*L;
  localparam int MINV = 32'sh80000000;
  localparam int MAXV = 32'sh7fffffff;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic lt = 1'b0, ack = 1'b0;
  logic signed [W-1:0] din [0:N-1];
  logic [3:0] clasa;
  logic valid, busy;

  logic lt1 = 1'b0, ack1 = 1'b0;
  logic signed [W-1:0] din1 [0:0];
  logic [0:0] clasa1;
  logic valid1, busy1;
`ifdef ARGMAX_MAX_VALUE_OUT_EN
  logic signed [W-1:0] val, val1;
`endif

  always #5 clock = ~clock;

  argmax_classifier #(.numar_neuroni(N), .latime(L)) dut (
    .clock(clock), .reset(reset), .layer_terminat(lt), .date_intrare(din),
    .clasa(clasa), .clasa_valid(valid), .clasa_ack(ack), .busy(busy)
`ifdef ARGMAX_MAX_VALUE_OUT_EN
    , .clasa_valoare(val)
`endif
  );

  argmax_classifier #(.numar_neuroni(1), .latime(L)) dut1 (
    .clock(clock), .reset(reset), .layer_terminat(lt1), .date_intrare(din1),
    .clasa(clasa1), .clasa_valid(valid1), .clasa_ack(ack1), .busy(busy1)
`ifdef ARGMAX_MAX_VALUE_OUT_EN
    , .clasa_valoare(val1)
`endif
  );

  typedef struct {
    logic [N-1:0][W-1:0] v;
    int exp_idx;
    int exp_val;
  } vec_t;

  typedef struct { int idx; int val; } exp_t;

  vec_t tbl [7];
  exp_t sb [$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a [N], input int ei, input int ev);
    vec_t r;
    for (int i = 0; i < N; i++) r.v[i] = a[i];
    r.exp_idx = ei;
    r.exp_val = ev;
    return r;
  endfunction

  task automatic load(input vec_t t);
    for (int i = 0; i < N; i++) din[i] = t.v[i];
  endtask

  // Caller has lt low for at least one edge; raising it here makes the next posedge edge 0.
  task automatic start_scan(input int ei, input int ev);
    exp_t e;
    e.idx = ei;
    e.val = ev;
    sb.push_back(e);
    lt = 1'b1;
  endtask

  // c0 = negedges already elapsed since start_scan. Result must appear after edge 9.
  task automatic wait_result(input string name, input int c0);
    int lat;
    exp_t e;
    lat = -1;
    for (int c = c0 + 1; c <= 40; c++) begin
      @(negedge clock);
      if (valid) begin
        lat = c - 1;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: clasa_valid never rose (required after edge %0d)", name, N-1);
    end else if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected result clasa=%0d, nothing expected", name, clasa);
    end else begin
      e = sb.pop_front();
      chk({name, " latency"}, lat, N-1);
      chk({name, " clasa"}, clasa, e.idx);
      chk({name, " busy"}, busy, 1);
`ifdef ARGMAX_MAX_VALUE_OUT_EN
      chk({name, " clasa_valoare"}, val, e.val);
`endif
    end
  endtask

  // Called at a negedge with the result valid.
  task automatic do_ack(input string name, input int exp_cls);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    chk({name, " valid after ack"}, valid, 0);
    chk({name, " busy after ack"}, busy, 0);
    chk({name, " clasa held"}, clasa, exp_cls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a [N];
    for (int i = 0; i < N; i++) din[i] = '0;
    din1[0] = '0;

    a = '{5, -3, 40, 7, 40, 0, -100, 12, 1, 2};           tbl[0] = mk(a, 2, 40);
    a = '{MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV+1};
                                                          tbl[1] = mk(a, 9, MINV+1);
    a = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};                  tbl[2] = mk(a, 0, 7);
    a = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};                  tbl[3] = mk(a, 0, 9);
    a = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, MAXV};      tbl[4] = mk(a, 9, MAXV);
    a = '{-100, -50, -50, -200, -7, -300, -7, -8, -9, -10}; tbl[5] = mk(a, 4, -7);
    a = '{0, 0, 0, 0, 0, 0, 0, -1, 3, 3};                 tbl[6] = mk(a, 8, 3);

    // Reset state.
    #1;
    chk("reset clasa", clasa, 0);
    chk("reset valid", valid, 0);
    chk("reset busy", busy, 0);
`ifdef ARGMAX_MAX_VALUE_OUT_EN
    chk("reset clasa_valoare", val, 0);
`endif
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven vectors; a held-high level must not retrigger after ack.
    foreach (tbl[k]) begin
      load(tbl[k]);
      lt = 1'b0;
      @(negedge clock);
      start_scan(tbl[k].exp_idx, tbl[k].exp_val);
      wait_result($sformatf("vec%0d", k), 0);
      do_ack($sformatf("vec%0d", k), tbl[k].exp_idx);
      repeat (5) @(negedge clock);
      chk($sformatf("vec%0d no retrigger busy", k), busy, 0);
      chk($sformatf("vec%0d no retrigger valid", k), valid, 0);
    end

    // Snapshot: inputs overwritten mid-scan, ack in SCAN ignored, result held 20 cycles.
    load(tbl[0]);
    lt = 1'b0;
    @(negedge clock);
    start_scan(2, 40);
    repeat (3) @(negedge clock);
    din[0] = 1000;
    din[2] = -1;
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    chk("snap busy in scan", busy, 1);
    wait_result("snap", 4);
    repeat (20) begin
      @(negedge clock);
      chk("hold valid", valid, 1);
      chk("hold clasa", clasa, 2);
    end
    do_ack("snap", 2);
    // A fresh 0->1 starts a new scan, and it now sees the modified inputs.
    lt = 1'b0;
    @(negedge clock);
    start_scan(0, 1000);
    wait_result("rescan", 0);
    do_ack("rescan", 0);

    // Ack and start on the same edge in DONE: the start is lost.
    load(tbl[6]);
    lt = 1'b0;
    @(negedge clock);
    start_scan(8, 3);
    @(negedge clock);
    lt = 1'b0;
    wait_result("ackstart", 1);
    ack = 1'b1;
    lt = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    chk("ackstart valid", valid, 0);
    chk("ackstart busy", busy, 0);
    repeat (3) @(negedge clock);
    chk("ackstart start lost", busy, 0);
    lt = 1'b0;

    // Asynchronous reset at scan cycle 4, then restart with lt held high.
    load(tbl[1]);
    @(negedge clock);
    start_scan(9, MINV+1);
    repeat (4) @(negedge clock);
    chk("pre-reset busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset valid", valid, 0);
    chk("async reset busy", busy, 0);
    chk("async reset clasa", clasa, 0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    sb.push_back('{9, MINV+1});
    wait_result("post-reset", 0);
    do_ack("post-reset", 9);
    lt = 1'b0;

    // Single-neuron instance: result on the start edge itself.
    din1[0] = -5;
    @(negedge clock);
    lt1 = 1'b1;
    @(negedge clock);
    chk("n1 valid", valid1, 1);
    chk("n1 clasa", clasa1, 0);
    chk("n1 busy", busy1, 1);
`ifdef ARGMAX_MAX_VALUE_OUT_EN
    chk("n1 clasa_valoare", val1, -5);
`endif
    ack1 = 1'b1;
    @(negedge clock);
    ack1 = 1'b0;
    chk("n1 valid after ack", valid1, 0);
    chk("n1 busy after ack", busy1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
